// File: rtl/core_sequencer_pkg.sv
// Opcode field constants shared by core_array and core_sequencer, plus sequencer state encoding.
// The capture test lives here so both sides of the array interface decode the same bits.
package core_sequencer_pkg;

    localparam int         OPC_W           = 16;
    localparam logic [1:0] OPC_MISC_PREFIX = 2'b11;
    localparam int         OPC_PREFIX_HI   = 15;
    localparam int         OPC_PREFIX_LO   = 14;
    localparam int         OPC_OUT_BIT     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // MISC-class opcode with the output-bit flag set: the array returns one pixel bit
    function automatic logic is_capture(input logic [OPC_W-1:0] op);
        return (op[OPC_PREFIX_HI:OPC_PREFIX_LO] == OPC_MISC_PREFIX) && op[OPC_OUT_BIT];
    endfunction

endpackage

// File: rtl/core_sequencer_prog_mem.sv
// Program store: PROG_DEPTH x 16, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a run abort.
// Write port always accepts; no backpressure.
module seq_prog_mem
    import core_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OPC_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OPC_W-1:0]  rdata
);

    logic [OPC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_sequencer.sv
// Replays a stored opcode program loop_cnt+1 times and packs returned capture bits into bytes.
// Latency: first opcode one edge after start is sampled; a captured bit lands two edges after issue.
// Backpressure: issue stalls while a byte is held unaccepted; up to two in-flight bits still land.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [ADDR_W-1:0] prog_last,
    input  logic [7:0]        loop_cnt,
    input  logic              start,
    input  logic              output_bit,
    output logic [15:0]       opcode,
    output logic              execute,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] last_q;
    logic [7:0]        iter;
    logic [7:0]        loop_q;
    logic [1:0]        flush_cnt;
    logic              cap_p1, cap_p2;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_nxt;
    logic [OPC_W-1:0]  mem_rdata;
    logic              mem_we;
    logic              issue_ok, issue, wrap, launch;

    seq_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    assign issue_ok  = !(pixel_valid && !pixel_ready);
    assign issue     = (state == RUN) && issue_ok;
    assign wrap      = (pc == last_q);
    assign launch    = (state == IDLE) && start;
    assign shift_nxt = {shift_q[6:0], output_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                busy   = 1'b0;
                mem_we = prog_we;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (issue && wrap && (iter == loop_q)) begin
                    state_nxt = FLUSH;
                end
            end
            // the last-issue cycle plus two empty cycles drains the capture pipeline
            FLUSH: begin
                if (flush_cnt == 2'd2) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode    <= '0;
            execute   <= 1'b0;
            pc        <= '0;
            iter      <= '0;
            last_q    <= '0;
            loop_q    <= '0;
            flush_cnt <= '0;
            cap_p1    <= 1'b0;
            cap_p2    <= 1'b0;
        end else begin
            cap_p1    <= issue && is_capture(mem_rdata);
            cap_p2    <= cap_p1;
            flush_cnt <= ((state == FLUSH) && (state_nxt == FLUSH)) ? flush_cnt + 2'd1 : 2'd0;
            execute   <= issue;
            if (launch) begin
                last_q <= prog_last;
                loop_q <= loop_cnt;
                pc     <= '0;
                iter   <= '0;
            end else if (issue) begin
                opcode <= mem_rdata;
                if (wrap) begin
                    pc   <= '0;
                    iter <= iter + 8'd1;
                end else begin
                    pc <= pc + ADDR_W'(1);
                end
            end
        end
    end

    // a byte completing on an accept edge replaces the accepted one without a valid gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
        end else begin
            if (launch || (state == DONE)) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (cap_p2) begin
                shift_q <= shift_nxt;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cap_p2 && (bit_cnt == 3'd7)) begin
                pixel_data  <= shift_nxt;
                pixel_valid <= 1'b1;
            end else if (pixel_valid && pixel_ready) begin
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed and randomized runs of core_sequencer against a queue-based reference model.
module tb_core_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [AW-1:0] prog_last;
    logic [7:0]    loop_cnt;
    logic          start;
    logic          output_bit;
    logic [15:0]   opcode;
    logic          execute;
    logic          busy;
    logic          done;
    logic [7:0]    pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;

    core_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_last   (prog_last),
        .loop_cnt    (loop_cnt),
        .start       (start),
        .output_bit  (output_bit),
        .opcode      (opcode),
        .execute     (execute),
        .busy        (busy),
        .done        (done),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          start_cyc;
    int          stab_err;
    logic [15:0] prog [DEPTH];
    logic [15:0] obs_ops[$];
    int          obs_op_cyc[$];
    logic [7:0]  obs_bytes[$];
    int          done_cyc[$];
    bit          bits_q[$];
    bit          fed_bits[$];
    bit          ready_rand  = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        prev_hold   = 1'b0;
    logic [7:0]  prev_data   = '0;
    logic        cap_ex;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything observed mid-cycle, away from the active edge.
    initial begin
        stab_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (execute) begin
                    obs_ops.push_back(opcode);
                    obs_op_cyc.push_back(cyc);
                end
                if (done) done_cyc.push_back(cyc);
                if (prev_hold && (!pixel_valid || pixel_data !== prev_data)) stab_err++;
                if (pixel_valid && pixel_ready) obs_bytes.push_back(pixel_data);
                prev_hold = pixel_valid && !pixel_ready;
                prev_data = pixel_data;
            end
        end
    end

    // Core array model: registers the next bit on the edge that consumes a capture opcode.
    initial begin
        output_bit = 1'b0;
        forever begin
            @(negedge clk);
            cap_ex = execute && !rst && (opcode[15:14] == 2'b11) && opcode[4];
            @(posedge clk);
            #1;
            if (cap_ex && !rst && bits_q.size() > 0) output_bit = bits_q.pop_front();
        end
    end

    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pixel_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = prog[i];
            @(posedge clk);
            #1;
        end
        prog_we = 1'b0;
    endtask

    task automatic set_bits(input int n, input logic [7:0] pattern, input bit rnd);
        bits_q.delete();
        fed_bits.delete();
        for (int i = 0; i < n; i++) begin
            bit bb;
            bb = rnd ? 1'($urandom_range(0, 1)) : pattern[7 - (i % 8)];
            bits_q.push_back(bb);
            fed_bits.push_back(bb);
        end
    endtask

    task automatic start_run(input int last, input int loops);
        obs_ops.delete();
        obs_op_cyc.delete();
        obs_bytes.delete();
        done_cyc.delete();
        stab_err  = 0;
        prog_last = AW'(last);
        loop_cnt  = 8'(loops);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cyc.size() == 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cyc.size() > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        ready_rand  = 1'b0;
        ready_fixed = 1'b1;
        while ((pixel_valid || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drained"}, 32'(pixel_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Reference: a run issues prog[0..last] loops+1 times; every capture op consumes the
    // next fed bit, each full group of eight forms one byte MSB-first, a tail is dropped.
    task automatic check_run(input string tag, input int last, input int loops);
        logic [15:0] exp_ops[$];
        logic [7:0]  exp_bytes[$];
        logic [7:0]  b;
        int          ncap;
        ncap = 0;
        for (int it = 0; it <= loops; it++) begin
            for (int i = 0; i <= last; i++) begin
                exp_ops.push_back(prog[i]);
                if (prog[i][15:14] == 2'b11 && prog[i][4]) ncap++;
            end
        end
        for (int k = 0; k + 8 <= ncap; k += 8) begin
            for (int j = 0; j < 8; j++) b[7 - j] = fed_bits[k + j];
            exp_bytes.push_back(b);
        end
        chk({tag, "_nops"}, 32'(obs_ops.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++)
            chk({tag, "_op"}, 32'(obs_ops[i]), 32'(exp_ops[i]));
        chk({tag, "_nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
            chk({tag, "_byte"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, "_done_once"}, 32'(done_cyc.size()), 32'd1);
        chk({tag, "_hold_stable"}, 32'(stab_err), 32'd0);
    endtask

    initial begin
        int n;
        int lp;
        int plen;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_last = '0;
        loop_cnt  = '0;
        start     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_execute", 32'(execute), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel_data", 32'(pixel_data), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Three-entry program, two passes, ready held high.
        prog[0] = 16'h0001; prog[1] = 16'h0002; prog[2] = 16'h0003;
        load(3);
        set_bits(0, 8'h00, 1'b0);
        start_run(2, 1);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        chk("t1_no_issue_yet", 32'(execute), 32'd0);
        wait_done("t1");
        chk("t1_first_issue_cyc", 32'(obs_op_cyc[0]), 32'(start_cyc + 2));
        chk("t1_back_to_back", 32'(obs_op_cyc[5] - obs_op_cyc[0]), 32'd5);
        chk("t1_done_latency", 32'(done_cyc[0] - obs_op_cyc[5]), 32'd3);
        chk("t1_idle_after", 32'(busy), 32'd0);
        drain("t1");
        check_run("t1", 2, 1);

        // Single instruction, single pass.
        prog[0] = 16'h1234;
        load(1);
        start_run(0, 0);
        wait_done("t2");
        drain("t2");
        check_run("t2", 0, 0);

        // One capture byte with ready low: byte outlives the run into IDLE.
        ready_fixed = 1'b0;
        prog[0] = 16'hC010;
        load(1);
        set_bits(8, 8'hB2, 1'b0);
        start_run(0, 7);
        wait_done("t3");
        chk("t3_valid_in_idle", 32'(pixel_valid), 32'd1);
        chk("t3_data_in_idle", 32'(pixel_data), 32'hB2);
        chk("t3_busy_low", 32'(busy), 32'd0);
        drain("t3");
        check_run("t3", 0, 7);

        // Two bytes with ready low: issue stalls after two in-flight captures.
        ready_fixed = 1'b0;
        set_bits(16, 8'hB2, 1'b0);
        start_run(0, 15);
        repeat (30) @(posedge clk);
        #1;
        chk("t4_issued_before_stall", 32'(obs_ops.size()), 32'd10);
        chk("t4_stalled_execute", 32'(execute), 32'd0);
        chk("t4_held_valid", 32'(pixel_valid), 32'd1);
        chk("t4_held_data", 32'(pixel_data), 32'hB2);
        chk("t4_none_accepted", 32'(obs_bytes.size()), 32'd0);
        ready_fixed = 1'b1;
        wait_done("t4");
        drain("t4");
        check_run("t4", 0, 15);

        // Continuous capture stream with ready high: three random bytes back to back.
        set_bits(24, 8'h00, 1'b1);
        start_run(0, 23);
        wait_done("t5");
        drain("t5");
        check_run("t5", 0, 23);

        // Program writes during a run are ignored.
        prog[0] = 16'hA5A5; prog[1] = 16'h0002; prog[2] = 16'h0003;
        load(3);
        set_bits(0, 8'h00, 1'b0);
        start_run(2, 3);
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        prog_we = 1'b0;
        wait_done("t6a");
        drain("t6a");
        check_run("t6a", 2, 3);
        start_run(2, 0);
        wait_done("t6b");
        drain("t6b");
        check_run("t6b", 2, 0);

        // Reset mid-run at pc=5, then the same program reruns from mem[0].
        for (int i = 0; i < 8; i++) prog[i] = 16'($urandom);
        prog[1][15:14] = 2'b11; prog[1][4] = 1'b1;
        load(8);
        set_bits(64, 8'h00, 1'b1);
        start_run(7, 2);
        n = 0;
        while (obs_ops.size() < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t7_reached_pc5", 32'(obs_ops.size()), 32'd5);
        rst = 1'b1;
        #1;
        chk("t7_rst_execute", 32'(execute), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_opcode", 32'(opcode), 32'd0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bits(64, 8'h00, 1'b1);
        start_run(7, 1);
        wait_done("t7");
        drain("t7");
        check_run("t7", 7, 1);

        // Randomized programs, loop counts, capture mixes and ready patterns.
        for (int r = 0; r < 6; r++) begin
            plen = $urandom_range(1, DEPTH);
            lp   = $urandom_range(0, 4);
            for (int i = 0; i < plen; i++) begin
                prog[i] = 16'($urandom);
                if ($urandom_range(0, 2) != 0) begin
                    prog[i][15:14] = 2'b11;
                    prog[i][4]     = 1'b1;
                end
            end
            load(plen);
            set_bits(128, 8'h00, 1'b1);
            ready_rand = 1'b1;
            start_run(plen - 1, lp);
            wait_done("rnd");
            drain("rnd");
            check_run("rnd", plen - 1, lp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, number of 16-bit program entries (power of two).
REQ-002 SHALL have parameter ADDR_W, default $clog2(PROG_DEPTH), program address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port prog_we  input  1  program write strobe.
REQ-006 SHALL have port prog_addr  input  ADDR_W  program write address.
REQ-007 SHALL have port prog_data  input  16  opcode to store.
REQ-008 SHALL have port prog_last  input  ADDR_W  index of last instruction; sampled at start.
REQ-009 SHALL have port loop_cnt  input  8  extra passes; iterations = loop_cnt+1; sampled at start.
REQ-010 SHALL have port start  input  1  run request, level-sampled.
REQ-011 SHALL have port output_bit  input  1  from core array, registered there on the edge that consumes the opcode.
REQ-012 SHALL have port opcode  output  16  registered opcode to core array.
REQ-013 SHALL have port execute  output  1  registered issue strobe to core array.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-016 SHALL have ports pixel_data output 8, pixel_valid output 1, pixel_ready input 1; valid/ready byte stream.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE: prog_we writes prog_data to mem[prog_addr]; prog_we outside IDLE SHALL be ignored.
REQ-019 IDLE & start: latch prog_last/loop_cnt, pc=0, iter=0, bit_cnt=0, shift register cleared, go RUN; start outside IDLE ignored.
REQ-020 RUN edge with issue_ok = !(pixel_valid & !pixel_ready): opcode<=mem[pc], execute<=1, pc advances.
REQ-021 RUN edge with !issue_ok: execute<=0, opcode holds, pc/iter hold (stall).
REQ-022 First opcode SHALL appear on the edge after the edge that samples start; back-to-back issue one per cycle without stall.
REQ-023 pc==prog_last at issue: pc wraps to 0, iter+1; if iter==loop_cnt -> go FLUSH instead.
REQ-024 Capture op = opcode[15:14]==2'b11 & opcode[4]==1; issued at edge E, output_bit SHALL be sampled at edge E+2 via two-stage capture-flag pipeline.
REQ-025 Captured bit SHALL shift in at LSB, shift left; first captured bit ends in pixel_data[7].
REQ-026 On 8th capture: shift register -> pixel_data, pixel_valid<=1, bit_cnt<=0.
REQ-027 pixel_valid SHALL stay high with pixel_data stable until an edge with pixel_ready=1.
REQ-028 New byte completing on same edge as pixel_ready=1: pixel_data loads new byte, pixel_valid stays 1.
REQ-029 In-flight captures (max 2) during stall SHALL still enter shift register; no bit lost.
REQ-030 FLUSH: execute<=0; stay 2 cycles until capture pipeline empty, then DONE.
REQ-031 DONE: done=1 for one cycle, then IDLE; partial byte (bit_cnt!=0) discarded.
REQ-032 done SHALL not wait for pixel acceptance; pending pixel_valid persists into IDLE.
REQ-033 prog_last=0, loop_cnt=0: exactly one instruction issued.

Reset
REQ-034 rst SHALL force IDLE, opcode=0, execute=0, busy=0, done=0, pixel_valid=0, pixel_data=0, pc/iter/bit_cnt/capture pipeline=0.
REQ-035 rst mid-run SHALL abort immediately; execute low from assertion; program memory SHALL not be reset and retains contents.

Structure
REQ-036 Opcode field constants (MISC prefix 2'b11, bits 15:14; output-bit flag bit 4) SHALL live in a shared include file used by core_array and core_sequencer.
REQ-037 Program storage SHALL be sub-module seq_prog_mem (sync write, async read, PROG_DEPTH x 16).

Verification
REQ-038 Load mem[0..2]=16'h0001,16'h0002,16'h0003, prog_last=2, loop_cnt=1, start -> execute high 6 consecutive cycles, opcodes 1,2,3,1,2,3, done pulse 3 cycles after last issue.
REQ-039 mem[0]=16'hC010, prog_last=0, loop_cnt=7, output_bit model returns 1,0,1,1,0,0,1,0 -> pixel_data=8'hB2, pixel_valid once.
REQ-040 Same as REQ-039 with loop_cnt=15, pixel_ready=0 -> issue stalls after 1st byte, second byte completes only after ready; bytes 8'hB2,8'hB2 in order, no loss.
REQ-041 rst asserted mid-run at pc=5 -> execute=0, busy=0 same cycle; new start reissues from mem[0] with prior contents.
REQ-042 prog_we during RUN to addr 0 -> mem[0] unchanged, read back via subsequent run.
REQ-043 Capture op ready=1 coinciding with byte completion -> back-to-back bytes, pixel_valid continuous.
